inst_controller_rr: RTL and testbench
=====================================

# inst_controller_rr

Multi-channel instruction memory controller between the per-core fetchers and global instruction memory. It arbitrates up to `NUM_CORES` fetch requests onto `NUM_MEM_CHAN` independent memory channels using round-robin fairness. Each channel tracks the owning core and completes full valid/ready handshakes on both the request and response sides. It replaces the single-channel, first-index-wins controller and drives one debug vector per channel.

## Interface
- `NUM_MEM_CHAN`, 2: independent memory channels, at least 1 and no more than `NUM_CORES`
- `NUM_CORES`, 4: fetcher clients, at least 2
- `MEM_ADDR_WIDTH`, 8: instruction address width
- `MEM_DATA_WIDTH`, 16: instruction width
- `CORE_IDX_W`, derived as `$clog2(NUM_CORES)`: core index width
---
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `fetch_req_val`  in  `NUM_CORES`  per-core fetch request valid
- `fetch_req_rdy`  out  `NUM_CORES`  per-core grant (combinational)
- `fetch_req_addr`  in  `NUM_CORES*MEM_ADDR_WIDTH`  packed addresses; core c occupies slice c
- `fetch_resp_val`  out  `NUM_CORES`  per-core response valid (registered)
- `fetch_resp_rdy`  in  `NUM_CORES`  core accepts response
- `fetch_resp_inst`  out  `NUM_CORES*MEM_DATA_WIDTH`  packed instructions (registered)
- `mem2fetch_req_val`  out  `NUM_MEM_CHAN`  per-channel memory request valid
- `mem2fetch_req_rdy`  in  `NUM_MEM_CHAN`  memory accepts request
- `mem2fetch_req_addr`  out  `NUM_MEM_CHAN*MEM_ADDR_WIDTH`  per-channel address
- `mem2fetch_resp_val`  in  `NUM_MEM_CHAN`  memory response valid
- `mem2fetch_resp_rdy`  out  `NUM_MEM_CHAN`  channel accepts response
- `mem2fetch_resp_inst`  in  `NUM_MEM_CHAN*MEM_DATA_WIDTH`  response data
- `chan_core`  out  `NUM_MEM_CHAN*CORE_IDX_W`  debug: core owned by each channel
- `core_busy`  out  `NUM_CORES`  debug: core has a transaction in flight

## Operation
- **Channel FSM states.**
  - `IDLE`: not owned.
  - `REQ`: `mem2fetch_req_val`=1. Moves to `WAIT` when val and rdy are both high.
  - `WAIT`: `mem2fetch_resp_rdy`=1. On val and rdy, captures the instruction and moves to `RESP`.
  - `RESP`: the owner's `fetch_resp_val`=1. Moves to `IDLE` when that core's `fetch_resp_rdy`=1.
- **Eligibility.** Core c is eligible when `fetch_req_val[c]` is high and `core_busy[c]` is low. Each core has at most one transaction outstanding.
- **Arbitration.**
  - The search covers cores starting at `rr_ptr` and wraps modulo `NUM_CORES`.
  - The lowest-index `IDLE` channel receives the first eligible core, the next `IDLE` channel the next eligible core, and so on.
  - When at least one grant occurs, `rr_ptr` becomes the last granted index plus 1, modulo `NUM_CORES`. Otherwise `rr_ptr` is unchanged.
- **Grant effects.**
  - `fetch_req_rdy[c]` is high in the grant cycle. The address is captured into the channel register.
  - `core_busy[c]` is set, and the channel stores c in `chan_core`.
- **Busy clear.** `core_busy[c]` clears on the `fetch_resp_val`/`fetch_resp_rdy` handshake. The core becomes eligible again in the following cycle.
- **Non-owned outputs.** `fetch_resp_inst` slices of cores not in `RESP` are 0. `mem2fetch_req_addr` is held while in `REQ`.

## Timing
- **Reset.** On reset, all outputs are 0, all channels are in `IDLE`, `rr_ptr`=0 and `core_busy`=0. Reset asserted mid-transaction abandons the transaction. The memory must be reset in the same cycle.
- **Minimum latency.**
  - Grant at T.
  - `mem2fetch_req_val` at T+1, accepted at T+1.
  - Memory response at T+2.
  - `fetch_resp_val` at T+3.
  - Channel back in `IDLE` at T+4 when the core is ready at T+3. The channel is grantable at T+4.
- **Handshake holds.**
  - `REQ` holds val and address indefinitely while `mem2fetch_req_rdy`=0.
  - `RESP` holds val and data while the core stalls.
- **Resource limits.**
  - If more cores are eligible than channels are `IDLE`, the surplus cores wait with `fetch_req_rdy`=0.
  - If all channels are busy, no grants occur and `rr_ptr` holds.
- **No response-side dependence.** `fetch_req_rdy` depends only on state and `fetch_req_val`, never on a response handshake.

## Structure
- **Package `inst_ctrl_pkg`.** Holds the channel state enum (`IDLE`, `REQ`, `WAIT`, `RESP`, 2 bits) and a `CORE_IDX_W` helper function.
- **Sub-module `inst_channel`.** One FSM instance per channel, holding the address, instruction and owner registers. It is instantiated with a generate loop.
- **Top level.** Contains the round-robin arbiter, `rr_ptr` and `core_busy`.

## Test plan
- **Single request.** Core 2 requests address 0x10 and memory returns 0x1234 with zero stall. Required: `fetch_resp_val[2]` at T+3 with instruction 0x1234, and `core_busy[2]` cleared at T+4.
- **All cores request, 2 channels.** All four cores assert simultaneously at reset exit. Required: grants go to cores 0 and 1, then 2 and 3, with `rr_ptr` at 2 and then at 0.
- **Fairness.** Cores 0 and 3 request continuously with `NUM_MEM_CHAN`=1. Required: grants alternate 0, 3, 0, 3 and neither core is starved.
- **Backpressure.** `mem2fetch_req_rdy`=0 for 5 cycles, then `fetch_resp_rdy`=0 for 3 cycles. Required: val, address and instruction are held stable, and no duplicate request is issued.
- **No re-grant of a busy core.** Core 1 keeps `fetch_req_val` high while its transaction is in flight. Required: no second grant to core 1 until the cycle after its response handshake.
- **Reset mid-operation.** Reset asserted while one channel is in `WAIT`. Required: all outputs are 0 the next cycle, and a new request completes normally afterwards.

Source files
------------

// File: rtl/inst_ctrl_pkg.sv
// Shared types for the round-robin instruction memory controller.
// Channel FSM encoding and core-index width helper.
package inst_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } chan_state_e;

    function automatic int core_idx_w(input int num_cores);
        return (num_cores > 1) ? $clog2(num_cores) : 1;
    endfunction

endpackage

// File: rtl/inst_controller_rr_if.sv
// Fetch-side and memory-side handshake bundle of the instruction controller.
// master = fetchers plus memory (environment), slave = the controller.
interface inst_controller_rr_if #(
    parameter int NUM_CORES      = 4,
    parameter int NUM_MEM_CHAN   = 2,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 16
);
    logic [NUM_CORES-1:0]                   fetch_req_val;
    logic [NUM_CORES-1:0]                   fetch_req_rdy;
    logic [NUM_CORES*MEM_ADDR_WIDTH-1:0]    fetch_req_addr;
    logic [NUM_CORES-1:0]                   fetch_resp_val;
    logic [NUM_CORES-1:0]                   fetch_resp_rdy;
    logic [NUM_CORES*MEM_DATA_WIDTH-1:0]    fetch_resp_inst;
    logic [NUM_MEM_CHAN-1:0]                mem2fetch_req_val;
    logic [NUM_MEM_CHAN-1:0]                mem2fetch_req_rdy;
    logic [NUM_MEM_CHAN*MEM_ADDR_WIDTH-1:0] mem2fetch_req_addr;
    logic [NUM_MEM_CHAN-1:0]                mem2fetch_resp_val;
    logic [NUM_MEM_CHAN-1:0]                mem2fetch_resp_rdy;
    logic [NUM_MEM_CHAN*MEM_DATA_WIDTH-1:0] mem2fetch_resp_inst;

    modport master (
        output fetch_req_val, fetch_req_addr, fetch_resp_rdy,
        output mem2fetch_req_rdy, mem2fetch_resp_val, mem2fetch_resp_inst,
        input  fetch_req_rdy, fetch_resp_val, fetch_resp_inst,
        input  mem2fetch_req_val, mem2fetch_req_addr, mem2fetch_resp_rdy
    );

    modport slave (
        input  fetch_req_val, fetch_req_addr, fetch_resp_rdy,
        input  mem2fetch_req_rdy, mem2fetch_resp_val, mem2fetch_resp_inst,
        output fetch_req_rdy, fetch_resp_val, fetch_resp_inst,
        output mem2fetch_req_val, mem2fetch_req_addr, mem2fetch_resp_rdy
    );
endinterface

// File: rtl/inst_channel.sv
// One memory channel: owns a core from grant until its response is consumed.
// One state per phase (REQ, WAIT, RESP); each phase holds its outputs until its handshake.
module inst_channel
    import inst_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grant,
    input  logic [IDX_W-1:0]  grant_core,
    input  logic [ADDR_W-1:0] grant_addr,
    output logic              req_val,
    input  logic              req_rdy,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              resp_val,
    output logic              resp_rdy,
    input  logic [DATA_W-1:0] resp_inst,
    input  logic              core_rdy,
    output logic              idle,
    output logic              resp_active,
    output logic [IDX_W-1:0]  owner,
    output logic [DATA_W-1:0] inst
);
    chan_state_e state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            req_addr <= '0;
            owner    <= '0;
            inst     <= '0;
        end else begin
            case (state)
                IDLE: if (grant) begin
                    state    <= REQ;
                    req_addr <= grant_addr;
                    owner    <= grant_core;
                end
                REQ:  if (req_rdy) state <= WAIT;
                WAIT: if (resp_val) begin
                    state <= RESP;
                    inst  <= resp_inst;
                end
                RESP: if (core_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign idle        = (state == IDLE);
    assign req_val     = (state == REQ);
    assign resp_rdy    = (state == WAIT);
    assign resp_active = (state == RESP);

endmodule

// File: rtl/inst_controller_rr.sv
// Round-robin arbiter mapping per-core fetch requests onto independent memory channels.
// Grant is combinational; response 3 cycles after grant at best; surplus cores wait with rdy low.
module inst_controller_rr
    import inst_ctrl_pkg::*;
#(
    parameter int NUM_MEM_CHAN   = 2,
    parameter int NUM_CORES      = 4,
    parameter int MEM_ADDR_WIDTH = 8,
    parameter int MEM_DATA_WIDTH = 16,
    localparam int CORE_IDX_W    = core_idx_w(NUM_CORES)
) (
    input  logic                               clk,
    input  logic                               reset,
    inst_controller_rr_if.slave                bus,
    output logic [NUM_MEM_CHAN*CORE_IDX_W-1:0] chan_core,
    output logic [NUM_CORES-1:0]               core_busy
);
    localparam int AW = MEM_ADDR_WIDTH;
    localparam int DW = MEM_DATA_WIDTH;

    logic [CORE_IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_CORES-1:0]    eligible, grant, done_core;
    logic [NUM_MEM_CHAN-1:0] ch_idle, ch_grant, ch_resp;
    logic [CORE_IDX_W-1:0]   ch_gcore [NUM_MEM_CHAN];
    logic [CORE_IDX_W-1:0]   ch_owner [NUM_MEM_CHAN];
    logic [AW-1:0]           ch_gaddr [NUM_MEM_CHAN];
    logic [DW-1:0]           ch_inst  [NUM_MEM_CHAN];

    assign eligible = bus.fetch_req_val & ~core_busy;

    // Walk cores from rr_ptr; each eligible core takes the lowest still-free channel.
    always_comb begin
        logic [NUM_MEM_CHAN-1:0] free;
        logic                    placed;
        int                      idx;
        free       = ch_idle;
        grant      = '0;
        ch_grant   = '0;
        rr_ptr_nxt = rr_ptr;
        placed     = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_MEM_CHAN; k++) begin
            ch_gcore[k] = '0;
            ch_gaddr[k] = '0;
        end
        for (int i = 0; i < NUM_CORES; i++) begin
            idx    = (int'(rr_ptr) + i) % NUM_CORES;
            placed = 1'b0;
            for (int k = 0; k < NUM_MEM_CHAN; k++) begin
                if (eligible[idx] && !placed && free[k]) begin
                    free[k]     = 1'b0;
                    placed      = 1'b1;
                    ch_grant[k] = 1'b1;
                    ch_gcore[k] = CORE_IDX_W'(idx);
                    ch_gaddr[k] = bus.fetch_req_addr[idx*AW +: AW];
                end
            end
            if (placed) begin
                grant[idx] = 1'b1;
                rr_ptr_nxt = CORE_IDX_W'((idx + 1) % NUM_CORES);
            end
        end
    end

    assign bus.fetch_req_rdy = reset ? '0 : grant;

    always_comb begin
        done_core           = '0;
        bus.fetch_resp_val  = '0;
        bus.fetch_resp_inst = '0;
        for (int k = 0; k < NUM_MEM_CHAN; k++) begin
            if (ch_resp[k]) begin
                bus.fetch_resp_val[ch_owner[k]]                     = 1'b1;
                bus.fetch_resp_inst[int'(ch_owner[k])*DW +: DW]     = ch_inst[k];
                done_core[ch_owner[k]] = bus.fetch_resp_rdy[ch_owner[k]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= '0;
            core_busy <= '0;
        end else begin
            rr_ptr    <= rr_ptr_nxt;
            core_busy <= (core_busy | grant) & ~done_core;
        end
    end

    for (genvar k = 0; k < NUM_MEM_CHAN; k++) begin : g_chan
        inst_channel #(
            .ADDR_W (AW),
            .DATA_W (DW),
            .IDX_W  (CORE_IDX_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .grant       (ch_grant[k]),
            .grant_core  (ch_gcore[k]),
            .grant_addr  (ch_gaddr[k]),
            .req_val     (bus.mem2fetch_req_val[k]),
            .req_rdy     (bus.mem2fetch_req_rdy[k]),
            .req_addr    (bus.mem2fetch_req_addr[k*AW +: AW]),
            .resp_val    (bus.mem2fetch_resp_val[k]),
            .resp_rdy    (bus.mem2fetch_resp_rdy[k]),
            .resp_inst   (bus.mem2fetch_resp_inst[k*DW +: DW]),
            .core_rdy    (bus.fetch_resp_rdy[ch_owner[k]]),
            .idle        (ch_idle[k]),
            .resp_active (ch_resp[k]),
            .owner       (ch_owner[k]),
            .inst        (ch_inst[k])
        );
        assign chan_core[k*CORE_IDX_W +: CORE_IDX_W] = ch_owner[k];
    end

endmodule

// File: tb/tb_inst_controller_rr.sv
// Directed bench: dut_a has two channels, dut_b one channel (fairness).
// Memory is a zero-latency lookup table; stalls come from mem_rdy / resp_en / fetch_resp_rdy.
module tb_inst_controller_rr;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_controller_rr_if #(.NUM_CORES(4), .NUM_MEM_CHAN(2), .MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16)) ifa ();
    inst_controller_rr_if #(.NUM_CORES(4), .NUM_MEM_CHAN(1), .MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16)) ifb ();

    logic [3:0] chan_core_a;
    logic [3:0] busy_a;
    logic [1:0] chan_core_b;
    logic [3:0] busy_b;

    inst_controller_rr #(.NUM_MEM_CHAN(2), .NUM_CORES(4), .MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave), .chan_core(chan_core_a), .core_busy(busy_a));
    inst_controller_rr #(.NUM_MEM_CHAN(1), .NUM_CORES(4), .MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave), .chan_core(chan_core_b), .core_busy(busy_b));

    logic [15:0] mem [256];
    logic        mem_rdy;
    logic        resp_en;

    assign ifa.mem2fetch_req_rdy   = {2{mem_rdy}};
    assign ifa.mem2fetch_resp_val  = {2{resp_en}};
    assign ifa.mem2fetch_resp_inst = {mem[ifa.mem2fetch_req_addr[15:8]], mem[ifa.mem2fetch_req_addr[7:0]]};
    assign ifb.mem2fetch_req_rdy   = mem_rdy;
    assign ifb.mem2fetch_resp_val  = resp_en;
    assign ifb.mem2fetch_resp_inst = mem[ifb.mem2fetch_req_addr];

    int fires_a = 0;
    int gq_b[$];
    always @(posedge clk) begin
        if (!reset) begin
            fires_a <= fires_a + $countones(ifa.mem2fetch_req_val & ifa.mem2fetch_req_rdy);
            for (int c = 0; c < 4; c++)
                if (ifb.fetch_req_val[c] && ifb.fetch_req_rdy[c]) gq_b.push_back(c);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ifa.fetch_req_val = '0;
        ifb.fetch_req_val = '0;
        next();
        next();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  val;
        logic [3:0]  rdy;
        logic [1:0]  mval;
        logic [3:0]  rval;
        logic [63:0] inst;
        logic [3:0]  busy;
        logic [1:0]  ptr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'(i), ~8'(i)};
        mem[8'h10] = 16'h1234;
        // Two-channel arbitration from reset exit: cores 0,1 first, then 2,3.
        tbl[0] = '{4'hF,    4'b0011, 2'b00, 4'h0,    64'h0,                    4'h0,    2'd0};
        tbl[1] = '{4'b1100, 4'b0000, 2'b11, 4'h0,    64'h0,                    4'b0011, 2'd2};
        tbl[2] = '{4'b1100, 4'b0000, 2'b00, 4'h0,    64'h0,                    4'b0011, 2'd2};
        tbl[3] = '{4'b1100, 4'b0000, 2'b00, 4'b0011, 64'h0000_0000_21DE_20DF, 4'b0011, 2'd2};
        tbl[4] = '{4'b1100, 4'b1100, 2'b00, 4'h0,    64'h0,                    4'h0,    2'd2};
        tbl[5] = '{4'b0000, 4'b0000, 2'b11, 4'h0,    64'h0,                    4'b1100, 2'd0};
        tbl[6] = '{4'b0000, 4'b0000, 2'b00, 4'h0,    64'h0,                    4'b1100, 2'd0};
        tbl[7] = '{4'b0000, 4'b0000, 2'b00, 4'b1100, 64'h23DC_22DD_0000_0000, 4'b1100, 2'd0};
        tbl[8] = '{4'b0000, 4'b0000, 2'b00, 4'h0,    64'h0,                    4'h0,    2'd0};

        ifa.fetch_req_val = '0;  ifa.fetch_req_addr = '0;  ifa.fetch_resp_rdy = 4'hF;
        ifb.fetch_req_val = '0;  ifb.fetch_req_addr = '0;  ifb.fetch_resp_rdy = 4'hF;
        mem_rdy = 1'b1;
        resp_en = 1'b1;

        // Reset state
        do_reset();
        chk("rst_busy",     64'(busy_a), 64'h0);
        chk("rst_mval",     64'(ifa.mem2fetch_req_val), 64'h0);
        chk("rst_rval",     64'(ifa.fetch_resp_val), 64'h0);
        chk("rst_chancore", 64'(chan_core_a), 64'h0);
        chk("rst_ptr",      64'(dut_a.rr_ptr), 64'h0);

        // Single request: core 2, address 0x10
        ifa.fetch_req_val = 4'b0100;  ifa.fetch_req_addr = 32'h0010_0000;
        #1 chk("t1_grant", 64'(ifa.fetch_req_rdy), 64'h4);
        next();
        ifa.fetch_req_val = '0;
        chk("t1_mval",  64'(ifa.mem2fetch_req_val), 64'h1);
        chk("t1_maddr", 64'(ifa.mem2fetch_req_addr), 64'h0010);
        chk("t1_owner", 64'(chan_core_a[1:0]), 64'h2);
        chk("t1_busy",  64'(busy_a), 64'h4);
        next();
        chk("t1_wait",  64'(ifa.mem2fetch_resp_rdy), 64'h1);
        chk("t1_rval0", 64'(ifa.fetch_resp_val), 64'h0);
        next();
        chk("t1_rval",  64'(ifa.fetch_resp_val), 64'h4);
        chk("t1_inst",  64'(ifa.fetch_resp_inst), 64'h0000_1234_0000_0000);
        next();
        chk("t1_busyclr", 64'(busy_a), 64'h0);
        chk("t1_rvalclr", 64'(ifa.fetch_resp_val), 64'h0);

        // All cores request at reset exit (table)
        do_reset();
        ifa.fetch_req_addr = 32'h2322_2120;
        for (int i = 0; i < 9; i++) begin
            ifa.fetch_req_val = tbl[i].val;
            #1;
            chk($sformatf("v%0d_rdy", i),  64'(ifa.fetch_req_rdy), 64'(tbl[i].rdy));
            chk($sformatf("v%0d_mval", i), 64'(ifa.mem2fetch_req_val), 64'(tbl[i].mval));
            chk($sformatf("v%0d_rval", i), 64'(ifa.fetch_resp_val), 64'(tbl[i].rval));
            chk($sformatf("v%0d_inst", i), ifa.fetch_resp_inst, tbl[i].inst);
            chk($sformatf("v%0d_busy", i), 64'(busy_a), 64'(tbl[i].busy));
            chk($sformatf("v%0d_ptr", i),  64'(dut_a.rr_ptr), 64'(tbl[i].ptr));
            next();
        end

        // Fairness on one channel: cores 0 and 3 request continuously
        do_reset();
        begin
            int n0;
            n0 = gq_b.size();
            ifb.fetch_req_val = 4'b1001;  ifb.fetch_req_addr = 32'h5000_0050;
            for (int i = 0; i < 20; i++) next();
            ifb.fetch_req_val = '0;
            chk("fair_count", 64'(gq_b.size() - n0), 64'd5);
            for (int j = 0; j < 5; j++)
                if (n0 + j < gq_b.size())
                    chk($sformatf("fair_g%0d", j), 64'(gq_b[n0+j]), (j % 2 == 1) ? 64'd3 : 64'd0);
        end

        // Backpressure: request side stalls 5 cycles, response side 3 cycles
        do_reset();
        begin
            int f0;
            f0 = fires_a;
            mem_rdy = 1'b0;
            ifa.fetch_req_val = 4'b0010;  ifa.fetch_req_addr = 32'h0000_3300;
            #1 chk("bp_grant", 64'(ifa.fetch_req_rdy), 64'h2);
            next();
            ifa.fetch_req_val = '0;
            for (int j = 0; j < 5; j++) begin
                chk($sformatf("bp_mval%0d", j),  64'(ifa.mem2fetch_req_val), 64'h1);
                chk($sformatf("bp_maddr%0d", j), 64'(ifa.mem2fetch_req_addr), 64'h0033);
                next();
            end
            mem_rdy = 1'b1;
            ifa.fetch_resp_rdy = 4'h0;
            #1 chk("bp_mval_acc", 64'(ifa.mem2fetch_req_val), 64'h1);
            next();
            chk("bp_wait",   64'(ifa.mem2fetch_resp_rdy), 64'h1);
            chk("bp_nodup",  64'(ifa.mem2fetch_req_val), 64'h0);
            next();
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("bp_rval%0d", j), 64'(ifa.fetch_resp_val), 64'h2);
                chk($sformatf("bp_inst%0d", j), ifa.fetch_resp_inst, 64'h0000_0000_33CC_0000);
                next();
            end
            ifa.fetch_resp_rdy = 4'hF;
            #1 chk("bp_rval_last", 64'(ifa.fetch_resp_val), 64'h2);
            next();
            chk("bp_done",  64'(ifa.fetch_resp_val), 64'h0);
            chk("bp_busy",  64'(busy_a), 64'h0);
            chk("bp_fires", 64'(fires_a - f0), 64'd1);
        end

        // No re-grant of a busy core: core 1 holds val throughout
        ifa.fetch_req_val = 4'b0010;  ifa.fetch_req_addr = 32'h0000_4000;
        #1 chk("rg_grant0", 64'(ifa.fetch_req_rdy), 64'h2);
        next();
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rg_hold%0d", j), 64'(ifa.fetch_req_rdy), 64'h0);
            next();
        end
        chk("rg_grant1", 64'(ifa.fetch_req_rdy), 64'h2);
        next();
        ifa.fetch_req_val = '0;
        for (int j = 0; j < 4; j++) next();
        chk("rg_idle", 64'(busy_a), 64'h0);

        // Reset while a channel waits on memory
        ifa.fetch_req_val = 4'b0001;  ifa.fetch_req_addr = 32'h0000_0044;
        #1 chk("mr_grant", 64'(ifa.fetch_req_rdy), 64'h1);
        next();
        ifa.fetch_req_val = '0;
        resp_en = 1'b0;
        next();
        chk("mr_wait", 64'(ifa.mem2fetch_resp_rdy), 64'h1);
        next();
        reset = 1'b1;
        next();
        chk("mr_busy",   64'(busy_a), 64'h0);
        chk("mr_rrdy",   64'(ifa.mem2fetch_resp_rdy), 64'h0);
        chk("mr_mval",   64'(ifa.mem2fetch_req_val), 64'h0);
        chk("mr_maddr",  64'(ifa.mem2fetch_req_addr), 64'h0);
        chk("mr_rval",   64'(ifa.fetch_resp_val), 64'h0);
        chk("mr_inst",   ifa.fetch_resp_inst, 64'h0);
        chk("mr_owner",  64'(chan_core_a), 64'h0);
        chk("mr_reqrdy", 64'(ifa.fetch_req_rdy), 64'h0);
        reset = 1'b0;
        resp_en = 1'b1;
        ifa.fetch_req_val = 4'b0001;
        #1 chk("mr_regrant", 64'(ifa.fetch_req_rdy), 64'h1);
        next();
        ifa.fetch_req_val = '0;
        next();
        next();
        chk("mr_rval2", 64'(ifa.fetch_resp_val), 64'h1);
        chk("mr_inst2", ifa.fetch_resp_inst, 64'h0000_0000_0000_44BB);
        next();
        chk("mr_busy2", 64'(busy_a), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
